// File: rtl/tlight_monitor.sv
// tlight_monitor: checks a traffic-light controller's phase sequence and drives a safe yellow flash on fault
module tlight_monitor #(
    parameter int YELLOW_MIN = 3,
    parameter int GREEN_MIN  = 15,
    parameter int STUCK_MAX  = 31,
    parameter int FLASH_HALF = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] ns,
    input  logic [2:0] we,
    output logic [2:0] ns_out,
    output logic [2:0] we_out,
    output logic       fault,
    output logic [2:0] fault_code
);
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam int FW = $clog2(2 * FLASH_HALF) + 1;
    localparam logic [4:0] Y_MIN = 5'(YELLOW_MIN);
    localparam logic [4:0] G_MIN = 5'(GREEN_MIN);
    localparam logic [4:0] S_MAX = 5'(STUCK_MAX);
    localparam logic [FW-1:0] FC_LAST = FW'(2 * FLASH_HALF - 1);
    localparam logic [FW-1:0] FC_HALF = FW'(FLASH_HALF);

    typedef enum logic [1:0] {INIT, RUN, FAULT} state_t;

    state_t state, state_n;
    logic [2:0] cur_ns, cur_we, cur_ns_n, cur_we_n;
    logic [2:0] ns_out_n, we_out_n, code_n, code;
    logic [4:0] dwell, dwell_n;
    logic [FW-1:0] fc, fc_n;
    logic first, first_n, fault_n;
    logic legal, in_yy, cur_yy, changed;

    assign in_yy   = ns == YEL && we == YEL;
    assign cur_yy  = cur_ns == YEL && cur_we == YEL;
    assign legal   = in_yy || (ns == RED && we == GRN) || (ns == GRN && we == RED);
    assign changed = {ns, we} != {cur_ns, cur_we};

    // Fault priority: lowest code wins; the first phase after INIT is exempt from minimum-duration checks
    assign code = !($onehot(ns) && $onehot(we))                      ? 3'd1 :
                  !legal                                             ? 3'd2 :
                  changed && !in_yy && !cur_yy                       ? 3'd3 :
                  changed && !first && cur_yy && dwell < Y_MIN       ? 3'd4 :
                  changed && !first && !cur_yy && dwell < G_MIN      ? 3'd5 :
                  !changed && dwell == S_MAX                         ? 3'd6 : 3'd0;

    // State register and all registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= INIT;
            ns_out     <= RED;
            we_out     <= RED;
            fault      <= 1'b0;
            fault_code <= 3'd0;
            cur_ns     <= RED;
            cur_we     <= RED;
            dwell      <= '0;
            first      <= 1'b0;
            fc         <= '0;
        end else begin
            state      <= state_n;
            ns_out     <= ns_out_n;
            we_out     <= we_out_n;
            fault      <= fault_n;
            fault_code <= code_n;
            cur_ns     <= cur_ns_n;
            cur_we     <= cur_we_n;
            dwell      <= dwell_n;
            first      <= first_n;
            fc         <= fc_n;
        end
    end

    // Next-state, phase tracking and lamp drive
    always_comb begin
        state_n  = state;
        ns_out_n = ns_out;
        we_out_n = we_out;
        fault_n  = fault;
        code_n   = fault_code;
        cur_ns_n = cur_ns;
        cur_we_n = cur_we;
        dwell_n  = dwell;
        first_n  = first;
        fc_n     = fc;
        case (state)
            INIT: begin
                ns_out_n = legal ? ns : RED;
                we_out_n = legal ? we : RED;
                if (legal) begin
                    state_n  = RUN;
                    cur_ns_n = ns;
                    cur_we_n = we;
                    dwell_n  = 5'd1;
                    first_n  = 1'b1;
                end
            end
            RUN: begin
                if (code != 3'd0) begin
                    state_n  = FAULT;
                    fault_n  = 1'b1;
                    code_n   = code;
                    fc_n     = '0;
                    ns_out_n = YEL;
                    we_out_n = YEL;
                end else begin
                    ns_out_n = ns;
                    we_out_n = we;
                    cur_ns_n = ns;
                    cur_we_n = we;
                    dwell_n  = changed ? 5'd1 : (dwell == 5'd31 ? dwell : dwell + 5'd1);
                    first_n  = first && !changed;
                end
            end
            FAULT: begin
                fc_n     = (fc == FC_LAST) ? '0 : fc + 1'b1;
                ns_out_n = (fc_n < FC_HALF) ? YEL : 3'b000;
                we_out_n = (fc_n < FC_HALF) ? YEL : 3'b000;
            end
            default: state_n = INIT;
        endcase
    end
endmodule
